// File: rtl/flag_register_if.sv
// Purpose: bundles the flag-update, POP AF, SCF/CCF and branch-condition signals of the F register.
// Latency: none; this file only carries wires between execute stage, sequencer and flag_register.
// Backpressure: none; every request is accepted on the edge it is presented.
interface flag_register_if;
  logic       i_ALU_Write;
  logic [3:0] i_ALU_F;
  logic [3:0] i_ALU_Mask;
  logic       i_Load;
  logic [7:0] i_Load_Data;
  logic [1:0] i_Op;
  logic       i_Cond_Req;
  logic [1:0] i_Cond;
  logic [7:0] o_F;
  logic [3:0] o_Flags;
  logic       o_Cond_Valid;
  logic       o_Cond_Taken;

  // Execute stage / sequencer side: drives requests, observes flags and branch results.
  modport master (
    output i_ALU_Write, i_ALU_F, i_ALU_Mask, i_Load, i_Load_Data, i_Op, i_Cond_Req, i_Cond,
    input  o_F, o_Flags, o_Cond_Valid, o_Cond_Taken
  );

  // Flag register side.
  modport slave (
    input  i_ALU_Write, i_ALU_F, i_ALU_Mask, i_Load, i_Load_Data, i_Op, i_Cond_Req, i_Cond,
    output o_F, o_Flags, o_Cond_Valid, o_Cond_Taken
  );
endinterface

// File: rtl/flag_register.sv
// Purpose: architectural F register (Z N H C) with masked ALU merge, POP AF, SCF/CCF and branch-condition evaluation.
// Latency: 1 cycle for flag updates and for condition results; condition sees the flags written on the same edge.
// Backpressure: none; one source wins per cycle by priority, losers are dropped, back-to-back requests are all serviced.
module flag_register #(
  parameter logic [3:0] RESET_FLAGS = 4'h0
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  flag_register_if.slave bus
);

  localparam logic [1:0] OP_SCF = 2'b01;
  localparam logic [1:0] OP_CCF = 2'b10;

  localparam logic [1:0] COND_NZ = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_NC = 2'b10;

  // Bit positions inside the {Z,N,H,C} nybble.
  localparam int Z_BIT = 3;
  localparam int C_BIT = 0;

  logic [3:0] flags;
  logic [3:0] next_flags;
  logic       cond_result;
  logic       cond_valid_q;
  logic       cond_taken_q;

  // The low nybble of a popped byte has no storage in F.
  logic unused_load_low;
  assign unused_load_low = ^bus.i_Load_Data[3:0];

  // Select the single update source for this edge: POP AF, then SCF, then CCF, then masked ALU merge.
  always_comb begin
    next_flags = flags;
    if (bus.i_Load) begin
      next_flags = bus.i_Load_Data[7:4];
    end else if (bus.i_Op == OP_SCF) begin
      next_flags = {flags[Z_BIT], 3'b001};
    end else if (bus.i_Op == OP_CCF) begin
      next_flags = {flags[Z_BIT], 2'b00, ~flags[C_BIT]};
    end else if (bus.i_ALU_Write) begin
      next_flags = (flags & ~bus.i_ALU_Mask) | (bus.i_ALU_F & bus.i_ALU_Mask);
    end
  end

  // Evaluate the branch condition against the value being committed, so a flag-setting op and its branch can pair.
  always_comb begin
    cond_result = 1'b0;
    case (bus.i_Cond)
      COND_NZ: cond_result = ~next_flags[Z_BIT];
      COND_Z:  cond_result =  next_flags[Z_BIT];
      COND_NC: cond_result = ~next_flags[C_BIT];
      default: cond_result =  next_flags[C_BIT];
    endcase
  end

  // Flag state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      flags <= RESET_FLAGS;
    end else begin
      flags <= next_flags;
    end
  end

  // Condition result register: valid pulses per request, taken holds until the next request.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cond_valid_q <= 1'b0;
      cond_taken_q <= 1'b0;
    end else begin
      cond_valid_q <= bus.i_Cond_Req;
      if (bus.i_Cond_Req) begin
        cond_taken_q <= cond_result;
      end
    end
  end

  assign bus.o_Flags      = flags;
  assign bus.o_F          = {flags, 4'b0000};
  assign bus.o_Cond_Valid = cond_valid_q;
  assign bus.o_Cond_Taken = cond_taken_q;

endmodule

// File: tb/tb_flag_register.sv
// Purpose: self-checking bench for flag_register using an expected-result queue.
// Latency: expects every flag/condition result one cycle after the driving edge.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_flag_register;

  logic i_Clk;
  logic i_Rst_n;

  flag_register_if bus ();

  flag_register dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic       vld;
    logic       taken;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the random phase.
  logic [3:0] m_flags;
  logic       m_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_ALU_Write = 1'b0;
    bus.i_ALU_F     = 4'h0;
    bus.i_ALU_Mask  = 4'h0;
    bus.i_Load      = 1'b0;
    bus.i_Load_Data = 8'h00;
    bus.i_Op        = 2'b00;
    bus.i_Cond_Req  = 1'b0;
    bus.i_Cond      = 2'b00;
  endtask

  // Drive one cycle of stimulus, queue the expected outcome, then pop and compare after the edge.
  task automatic cycle(input string tag,
                       input logic load, input logic [7:0] ld, input logic [1:0] op,
                       input logic wr, input logic [3:0] f, input logic [3:0] mask,
                       input logic req, input logic [1:0] cond,
                       input logic [3:0] e_flags, input logic e_vld, input logic e_taken);
    exp_t e;
    bus.i_Load      = load;
    bus.i_Load_Data = ld;
    bus.i_Op        = op;
    bus.i_ALU_Write = wr;
    bus.i_ALU_F     = f;
    bus.i_ALU_Mask  = mask;
    bus.i_Cond_Req  = req;
    bus.i_Cond      = cond;
    sb.push_back('{tag, e_flags, e_vld, e_taken});
    @(posedge i_Clk);
    #1;
    idle_inputs();
    e = sb.pop_front();
    check({e.tag, ".flags"}, 32'(bus.o_Flags), 32'(e.flags));
    check({e.tag, ".F"},     32'(bus.o_F), 32'({e.flags, 4'h0}));
    check({e.tag, ".vld"},   32'(bus.o_Cond_Valid), 32'(e.vld));
    check({e.tag, ".taken"}, 32'(bus.o_Cond_Taken), 32'(e.taken));
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic load, input logic [7:0] ld,
                                            input logic [1:0] op, input logic wr,
                                            input logic [3:0] f, input logic [3:0] mask);
    logic [3:0] r;
    r = cur;
    if (load) r = ld[7:4];
    else if (op == 2'b01) begin r[2] = 1'b0; r[1] = 1'b0; r[0] = 1'b1; end
    else if (op == 2'b10) begin r[2] = 1'b0; r[1] = 1'b0; r[0] = ~cur[0]; end
    else if (wr) begin
      for (int k = 0; k < 4; k++) if (mask[k]) r[k] = f[k];
    end
    return r;
  endfunction

  function automatic logic model_cond(input logic [3:0] fl, input logic [1:0] cond);
    case (cond)
      2'b00:   return !fl[3];
      2'b01:   return fl[3];
      2'b10:   return !fl[0];
      default: return fl[0];
    endcase
  endfunction

  initial begin
    idle_inputs();
    i_Rst_n = 1'b0;
    #3;
    check("reset.F",     32'(bus.o_F), 32'h00);
    check("reset.vld",   32'(bus.o_Cond_Valid), 32'h0);
    check("reset.taken", 32'(bus.o_Cond_Taken), 32'h0);
    @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;

    // POP AF: low nybble discarded.
    cycle("pop5F",   1, 8'h5F, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b0101, 0, 0);
    cycle("pop10",   1, 8'h10, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b0001, 0, 0);
    // INC-style masked write preserving C, then an all-zero mask no-op.
    cycle("alu_inc", 0, 8'h00, 2'b00, 1, 4'b1110, 4'b1110, 0, 2'b00, 4'b1111, 0, 0);
    cycle("alu_m0",  0, 8'h00, 2'b00, 1, 4'b0000, 4'b0000, 0, 2'b00, 4'b1111, 0, 0);
    cycle("hold",    0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b1111, 0, 0);
    // CCF / SCF / CCF.
    cycle("ccf1",    0, 8'h00, 2'b10, 0, 4'h0, 4'h0, 0, 2'b00, 4'b1000, 0, 0);
    cycle("scf",     0, 8'h00, 2'b01, 0, 4'h0, 4'h0, 0, 2'b00, 4'b1001, 0, 0);
    cycle("ccf2",    0, 8'h00, 2'b10, 0, 4'h0, 4'h0, 0, 2'b00, 4'b1000, 0, 0);
    // Priority collisions.
    cycle("pri_load",1, 8'h10, 2'b01, 1, 4'hF, 4'hF, 0, 2'b00, 4'b0001, 0, 0);
    cycle("pri_scf", 0, 8'h00, 2'b01, 1, 4'hF, 4'hF, 0, 2'b00, 4'b0001, 0, 0);
    cycle("pri_ccf", 0, 8'h00, 2'b10, 1, 4'hF, 4'hF, 0, 2'b00, 4'b0000, 0, 0);
    cycle("op11_alu",0, 8'h00, 2'b11, 1, 4'b1010, 4'hF, 0, 2'b00, 4'b1010, 0, 0);
    // Forwarding: Z set by the ALU on the same edge as the Z test.
    cycle("clr",     1, 8'h00, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b0000, 0, 0);
    cycle("fwd_z",   0, 8'h00, 2'b00, 1, 4'b1000, 4'b1000, 1, 2'b01, 4'b1000, 1, 1);
    cycle("fwd_hold",0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b1000, 0, 1);
    cycle("ld01",    1, 8'h10, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b0001, 0, 1);
    cycle("b2b_nz",  0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 1, 2'b00, 4'b0001, 1, 1);
    cycle("b2b_c",   0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 1, 2'b11, 4'b0001, 1, 1);
    cycle("cond_z0", 0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 1, 2'b01, 4'b0001, 1, 0);
    cycle("cond_nc0",0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 1, 2'b10, 4'b0001, 1, 0);
    cycle("cond_idle",0,8'h00, 2'b00, 0, 4'h0, 4'h0, 0, 2'b00, 4'b0001, 0, 0);

    // Random phase against the reference model.
    m_flags = 4'b0001;
    m_taken = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic       load, wr, req;
      logic [7:0] ld;
      logic [1:0] op, cond;
      logic [3:0] f, mask, nf;
      load = ($urandom_range(0, 7) == 0);
      ld   = 8'($urandom);
      op   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      wr   = 1'($urandom);
      f    = 4'($urandom);
      mask = 4'($urandom);
      req  = 1'($urandom);
      cond = 2'($urandom);
      nf   = model_next(m_flags, load, ld, op, wr, f, mask);
      if (req) m_taken = model_cond(nf, cond);
      m_flags = nf;
      cycle("rand", load, ld, op, wr, f, mask, req, cond, nf, req, m_taken);
    end

    // Mid-cycle asynchronous reset with live state and a valid pulse outstanding.
    cycle("pre_rst", 1, 8'hFF, 2'b00, 0, 4'h0, 4'h0, 1, 2'b01, 4'b1111, 1, 1);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("arst.F",     32'(bus.o_F), 32'h00);
    check("arst.flags", 32'(bus.o_Flags), 32'h0);
    check("arst.vld",   32'(bus.o_Cond_Valid), 32'h0);
    check("arst.taken", 32'(bus.o_Cond_Taken), 32'h0);
    // Write and request presented while reset is held are lost.
    bus.i_ALU_Write = 1'b1;
    bus.i_ALU_F     = 4'hF;
    bus.i_ALU_Mask  = 4'hF;
    bus.i_Cond_Req  = 1'b1;
    bus.i_Cond      = 2'b00;
    @(posedge i_Clk);
    #1;
    check("rst_hold.F",   32'(bus.o_F), 32'h00);
    check("rst_hold.vld", 32'(bus.o_Cond_Valid), 32'h0);
    idle_inputs();
    i_Rst_n = 1'b1;
    cycle("post_rst", 0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 1, 2'b00, 4'b0000, 1, 1);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/flag_register.md
# flag_register

Architectural F register of the CPU core and consumer of the flag outputs produced by the 8-bit ALU, the 8-bit incrementer/decrementer and the other arithmetic units. Stores Z N H C, merges masked flag updates from the execute stage, implements POP AF, SCF and CCF, and registers branch-condition results (NZ, Z, NC, C) for the control unit. Sits between the ALU outputs and the sequencer's conditional JP/JR/CALL/RET logic.

## Interface
Parameters:
- RESET_FLAGS, 4'h0, Z N H C value loaded on reset

Ports:
- i_Clk  in  1  core clock, all state on rising edge
- i_Rst_n  in  1  asynchronous active-low reset
- i_ALU_Write  in  1  commit i_ALU_F this cycle
- i_ALU_F  in  4  new flags from an arithmetic unit, order {Z,N,H,C}
- i_ALU_Mask  in  4  per-bit update enable, order {Z,N,H,C}; 0 = bit keeps stored value
- i_Load  in  1  POP AF: load flags from i_Load_Data
- i_Load_Data  in  8  byte popped into F; bits [7:4] = Z N H C, [3:0] ignored
- i_Op  in  2  00 none, 01 SCF, 10 CCF, 11 reserved (no-op)
- i_Cond_Req  in  1  request evaluation of i_Cond
- i_Cond  in  2  00 NZ, 01 Z, 10 NC, 11 C
- o_F  out  8  {Z,N,H,C,4'b0000}, registered
- o_Flags  out  4  {Z,N,H,C}, registered, fed back to ALUs as old flags
- o_Cond_Valid  out  1  one-cycle pulse, result of request from previous cycle
- o_Cond_Taken  out  1  condition true; held until next valid

## Operation
- Single 4-bit state register flags = {Z,N,H,C}; o_Flags = flags, o_F = {flags,4'b0}. Low nybble of F is never storable and always reads 0.
- Next-state computation, highest priority first, exactly one source per cycle:
  - i_Load: flags <= i_Load_Data[7:4].
  - i_Op=01 (SCF): N<=0, H<=0, C<=1, Z unchanged.
  - i_Op=10 (CCF): N<=0, H<=0, C<=~C, Z unchanged.
  - i_ALU_Write: for each bit k, flags[k] <= i_ALU_Mask[k] ? i_ALU_F[k] : flags[k].
  - otherwise hold. i_Op=11 behaves as none.
- Lower-priority requests in a collision are discarded, not queued.
- i_ALU_Write with i_ALU_Mask=0 is a legal no-op.
- Condition evaluation uses next_flags (value being written on the same edge), so an ALU op and a dependent branch may issue in the same cycle:
  - NZ = ~Z_next, Z = Z_next, NC = ~C_next, C = C_next.
- On i_Cond_Req: o_Cond_Valid <= 1, o_Cond_Taken <= evaluated result. Without request: o_Cond_Valid <= 0, o_Cond_Taken holds.
- Back-to-back requests produce back-to-back valid pulses; no stall, no busy.

## Timing
- Reset (async assert, any time): flags = RESET_FLAGS, o_F = {RESET_FLAGS,4'b0}, o_Cond_Valid = 0, o_Cond_Taken = 0. Release is synchronised by the reset controller upstream; first update is on the first edge with i_Rst_n high.
- Reset asserted in the same cycle as a write or request: write and request are lost; o_Cond_Valid stays 0.
- Flag update latency 1 cycle: inputs sampled on edge N, visible on o_Flags/o_F after edge N.
- Condition latency 1 cycle: request at edge N, o_Cond_Valid high for exactly the cycle after edge N, result reflects flags including any update committed at edge N.
- No combinational path from any input to any output.

## Test plan
- Reset: drive i_Rst_n=0 mid-cycle with flags=4'hF -> o_F=8'h00, o_Cond_Valid=0 immediately, before next clock edge.
- Masked write: flags=4'b0001, i_ALU_Write=1, i_ALU_F=4'b1110, i_ALU_Mask=4'b1110 (INC-style, C preserved) -> o_F=8'hF0 next cycle; repeat with mask 4'b0000 -> o_F unchanged.
- POP AF: i_Load_Data=8'h5F -> o_F=8'h50, o_Flags=4'b0101; low nybble never nonzero.
- SCF/CCF: flags=4'b1111, i_Op=10 -> 4'b1000 (o_F=8'h80); then i_Op=01 -> 4'b1001 (o_F=8'h90); then i_Op=10 -> 4'b1000.
- Priority: same cycle i_Load=1 (8'h10), i_Op=01, i_ALU_Write=1 with mask 4'hF and F=4'hF -> o_F=8'h10; drop i_Load, keep others -> SCF wins.
- Forwarding: flags Z=0, same cycle i_ALU_Write F=4'b1000 mask 4'b1000 and i_Cond_Req i_Cond=01 -> next cycle o_Cond_Valid=1, o_Cond_Taken=1; following cycle with no request o_Cond_Valid=0, o_Cond_Taken stays 1; consecutive requests NZ then C on flags 4'b0001 -> valid two cycles, taken 1 then 1.
